// File: rtl/semaforo_pkg.sv
// Shared state codes and light-head encodings for the two-road traffic light.
package semaforo_pkg;

  typedef enum logic [2:0] {
    StAg = 3'd0,
    StAy = 3'd1,
    StR1 = 3'd2,
    StBg = 3'd3,
    StBy = 3'd4,
    StR2 = 3'd5,
    StFl = 3'd6
  } state_e;

  localparam logic [2:0] LUZ_VERDE    = 3'b100;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b001;
  localparam logic [2:0] LUZ_APAGADO  = 3'b000;

  // Night-mode head: yellow while the flash bit is set, dark otherwise.
  function automatic logic [2:0] luz_pisca(input logic flash);
    return flash ? LUZ_AMARELO : LUZ_APAGADO;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Phase timer: counts up from 0 and saturates at sat_at-1; done flags the last cycle.
module semaforo_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] sat_at,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // Terminal value reached; sat_at is never zero.
  always_comb begin
    done = (count_q == (sat_at - One));
  end

  // Clear has priority; otherwise count until the terminal value and hold there.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !done) begin
      count_d = count_q + One;
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/semaforo_param.sv
// Two-road traffic-light controller: A rests green, B served on latched request,
// all-red clearance between greens, flashing yellow in night mode.
module semaforo_param
  import semaforo_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GREEN_A_MIN = 4,
  parameter int unsigned YELLOW      = 2,
  parameter int unsigned ALL_RED     = 1,
  parameter int unsigned GREEN_B     = 3,
  parameter int unsigned FLASH_HALF  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       night,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] phase,
  output logic       req_pending
);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             flash_q, flash_d;
  logic [2:0]       a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] sat_at;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             tmr_clr;
  logic             unused_count;

  // Duration of the current state; in FL it is the flash half-period.
  always_comb begin
    unique case (state_q)
      StAy, StBy: sat_at = CNT_W'(YELLOW);
      StR1, StR2: sat_at = CNT_W'(ALL_RED);
      StBg:       sat_at = CNT_W'(GREEN_B);
      StFl:       sat_at = CNT_W'(FLASH_HALF);
      default:    sat_at = CNT_W'(GREEN_A_MIN);
    endcase
  end

  // Next state: AG waits for request after the minimum, night wins; timed states chain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAg: begin
        if (night) begin
          state_d = StFl;
        end else if (done && req_q) begin
          state_d = StAy;
        end
      end
      StAy: if (done) state_d = StR1;
      StR1: if (done) state_d = StBg;
      StBg: if (done) state_d = StBy;
      StBy: if (done) state_d = StR2;
      StR2: if (done) state_d = StAg;
      StFl: if (!night) state_d = StR2;
      default: state_d = StAg;
    endcase
  end

  // Timer restarts on every state change and at each flash half-period boundary.
  always_comb begin
    tmr_clr = (state_d != state_q) || ((state_q == StFl) && done);
  end

  // Request latch: set in AG/AY/R2, cleared when B is served or night mode begins.
  always_comb begin
    req_d = req_q;
    if (bt && ((state_q == StAg) || (state_q == StAy) || (state_q == StR2))) begin
      req_d = 1'b1;
    end
    if ((state_q == StR1) && (state_d == StBg)) begin
      req_d = 1'b0;
    end
    if ((state_d == StFl) && (state_q != StFl)) begin
      req_d = 1'b0;
    end
  end

  // Flash bit: forced on at FL entry, toggled at each half-period end.
  always_comb begin
    flash_d = flash_q;
    if ((state_d == StFl) && (state_q != StFl)) begin
      flash_d = 1'b1;
    end else if ((state_q == StFl) && done) begin
      flash_d = ~flash_q;
    end
  end

  // Light heads decoded from the upcoming state so they register with it.
  always_comb begin
    a_d = LUZ_VERMELHO;
    b_d = LUZ_VERMELHO;
    unique case (state_d)
      StAg: a_d = LUZ_VERDE;
      StAy: a_d = LUZ_AMARELO;
      StBg: b_d = LUZ_VERDE;
      StBy: b_d = LUZ_AMARELO;
      StFl: begin
        a_d = luz_pisca(flash_d);
        b_d = luz_pisca(flash_d);
      end
      default: ;
    endcase
  end

  // State, request, flash and light registers; reset aborts any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAg;
      req_q   <= 1'b0;
      flash_q <= 1'b1;
      a_q     <= LUZ_VERDE;
      b_q     <= LUZ_VERMELHO;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      flash_q <= flash_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  semaforo_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (1'b1),
    .sat_at(sat_at),
    .count (count),
    .done  (done)
  );

  assign unused_count = ^count;

  assign A           = a_q;
  assign B           = b_q;
  assign phase       = state_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_semaforo_param.sv
// Randomised bench for semaforo_param against a phase/elapsed-time reference model.
module tb_semaforo_param;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GMIN  = 4;
  localparam int unsigned YEL   = 2;
  localparam int unsigned ARED  = 1;
  localparam int unsigned GB    = 3;
  localparam int unsigned FH    = 2;

  logic       clk = 1'b0;
  logic       rst, bt, night;
  logic [2:0] a, b, phase;
  logic       req_pending;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: phase number, cycles spent in it, request and flash bits.
  int m_st, m_el, m_req, m_flash;

  always #5 clk = ~clk;

  semaforo_param #(
    .CNT_W      (CNT_W),
    .GREEN_A_MIN(GMIN),
    .YELLOW     (YEL),
    .ALL_RED    (ARED),
    .GREEN_B    (GB),
    .FLASH_HALF (FH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bt         (bt),
    .night      (night),
    .A          (a),
    .B          (b),
    .phase      (phase),
    .req_pending(req_pending)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
    checks++;
    if (obs != exp_v) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      1, 4:    return YEL;
      2, 5:    return ARED;
      3:       return GB;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit b_in, input bit n_in);
    int ns;
    if (r) begin
      m_st = 0; m_el = 0; m_req = 0; m_flash = 1;
      return;
    end
    ns = m_st;
    case (m_st)
      0: begin
        if (n_in) ns = 6;
        else if (m_req != 0 && m_el >= int'(GMIN) - 1) ns = 1;
      end
      6: if (!n_in) ns = 5;
      default: if (m_el >= dur(m_st) - 1) ns = (m_st == 5) ? 0 : m_st + 1;
    endcase
    if (b_in && (m_st == 0 || m_st == 1 || m_st == 5)) m_req = 1;
    if (m_st == 2 && ns == 3) m_req = 0;
    if (ns == 6 && m_st != 6) begin
      m_req   = 0;
      m_flash = 1;
    end else if (m_st == 6 && ns == 6 && ((m_el + 1) % int'(FH)) == 0) begin
      m_flash = 1 - m_flash;
    end
    m_el = (ns == m_st) ? m_el + 1 : 0;
    m_st = ns;
  endtask

  function automatic int unsigned exp_head(input bit road_b);
    case (m_st)
      0:       return road_b ? 1 : 4;
      1:       return road_b ? 1 : 2;
      3:       return road_b ? 4 : 1;
      4:       return road_b ? 2 : 1;
      6:       return (m_flash != 0) ? 2 : 0;
      default: return 1;
    endcase
  endfunction

  // Called on a falling edge: drive, take the rising edge, compare 1 time unit later.
  task automatic tick(input bit r, input bit b_in, input bit n_in);
    rst = r; bt = b_in; night = n_in;
    @(posedge clk);
    model_step(r, b_in, n_in);
    #1;
    cyc++;
    check("phase", phase, m_st);
    check("A", a, exp_head(1'b0));
    check("B", b, exp_head(1'b1));
    check("req_pending", req_pending, m_req);
    @(negedge clk);
  endtask

  initial begin
    bit nl;
    rst = 1'b1; bt = 1'b0; night = 1'b0;
    m_st = 0; m_el = 0; m_req = 0; m_flash = 1;
    @(negedge clk);

    // Reset, then idle: A holds green.
    tick(1, 0, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 0, 0);

    // Single request pulse on the 10th cycle after reset.
    tick(1, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 15; i++) tick(0, 0, 0);

    // Request right after reset: minimum green honoured.
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 15; i++) tick(0, 0, 0);

    // bt held high through several cycles.
    for (int i = 0; i < 30; i++) tick(0, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);

    // Night mode from AG with bt pressed, then release.
    for (int i = 0; i < 12; i++) tick(0, i[0], 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);

    // Night raised during BG: B sequence completes first.
    tick(0, 1, 0);
    for (int i = 0; i < 40 && m_st != 3; i++) tick(0, 0, 0);
    check("reach_bg_night", phase, 3);
    for (int i = 0; i < 15; i++) tick(0, 0, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);

    // Reset while in BG aborts the phase.
    for (int i = 0; i < 40 && m_st != 3; i++) tick(0, 1, 0);
    check("reach_bg_rst", phase, 3);
    tick(1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0);

    // Random traffic.
    nl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59) == 0) nl = ~nl;
      tick($urandom_range(299) == 0, $urandom_range(7) == 0, nl);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/semaforo_param.md
Name: semaforo_param

Overview:
Parametrised two-road traffic-light controller. Main road A rests on green; side road B is served only on a latched request from button bt. All phase durations are parameters, all-red clearance phases separate the two greens, and a night input puts both heads into flashing yellow. Sits at top level and drives the light-head one-hot buses directly.

Parameters:
CNT_W, 8, phase-timer width; every duration below must be in 1..2^CNT_W-1
GREEN_A_MIN, 4, minimum cycles A stays green before a request is honoured
YELLOW, 2, yellow duration for both roads, in cycles
ALL_RED, 1, all-red clearance duration, in cycles
GREEN_B, 3, B green duration, in cycles
FLASH_HALF, 2, cycles per on or off half-period in night mode

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
bt  in  1  side-road request; level or pulse, sampled each cycle
night  in  1  night-mode request, level
A  out  3  road A head, one-hot: 100 green, 010 yellow, 001 red, 000 dark
B  out  3  road B head, same encoding
phase  out  3  current FSM state code
req_pending  out  1  latched side-road request

Behaviour:
- Everything is registered. A, B and phase update on the same edge as the state register.
- Reset (rst=1 at an edge, taking priority over everything): state AG, A=100, B=001, timer=0, req_pending=0, flash bit=1. Reset mid-phase aborts the phase immediately.
- States (codes): AG=0, AY=1, R1=2, BG=3, BY=4, R2=5, FL=6. Codes 7 and above are unreachable and recover to AG on the next edge.
- Lights by state:
  - AG: A=100, B=001
  - AY: A=010, B=001
  - R1 and R2: A=001, B=001
  - BG: A=001, B=100
  - BY: A=001, B=010
  - FL: A=B=010 when the flash bit is 1, A=B=000 when it is 0
- Timer:
  - Cleared on every state change.
  - In a timed state of duration D, the timer counts 0..D-1, and the transition occurs on the edge where timer==D-1. The state therefore lasts exactly D cycles.
- AG:
  - Timer increments up to GREEN_A_MIN-1, then saturates.
  - If night=1: go to FL on the next edge, regardless of timer (night has priority over request).
  - Else if timer==GREEN_A_MIN-1 and req_pending=1: go to AY.
  - Otherwise stay in AG. With no request, A holds green indefinitely.
- Timed sequence: AY (YELLOW) -> R1 (ALL_RED) -> BG (GREEN_B) -> BY (YELLOW) -> R2 (ALL_RED) -> AG. The night input is ignored in AY through R2 and is acted on once back in AG.
- req_pending:
  - Set: req_pending <= 1 when bt=1 in AG, AY, R2.
  - Ignored: bt is ignored in R1, BG, BY and FL.
  - Cleared on the R1->BG transition and on entry to FL.
  - Latency: bt at edge t in AG after the minimum makes req_pending=1 after t; AY is entered after t+1.
- FL:
  - Flash bit starts at 1 on entry. A flash counter toggles the bit every FLASH_HALF cycles.
  - When night=0 is seen: go to R2 (full ALL_RED), then AG. Exit may occur in either flash half.
- Widths: all comparisons are unsigned at CNT_W bits, with no wrap. The AG timer saturates rather than wrapping.

Decomposition:
- Package semaforo_pkg holds:
  - the state codes AG..FL
  - the light constants LUZ_VERDE=3'b100, LUZ_AMARELO=3'b010, LUZ_VERMELHO=3'b001, LUZ_APAGADO=3'b000
- One sub-module, semaforo_timer (CNT_W). Inputs: clr, en, sat_at. Outputs: count and done (count==target-1).
- The FSM, request latch and flash logic live in semaforo_param.

Test Plan:
- rst held 2 cycles, bt=0, night=0, run 50 cycles -> A=100, B=001, phase=0 throughout; req_pending=0.
- One-cycle bt pulse at cycle 10 after reset (defaults):
  - req_pending=1 from cycle 11; AY from cycle 12 for 2 cycles; R1 for 1 cycle; BG 3; BY 2; R2 1; back to AG at cycle 21.
  - req_pending clears at the R1->BG edge.
- bt pulse at cycle 1 after reset -> A leaves green no earlier than cycle 4 (GREEN_A_MIN honoured); sequence otherwise as above.
- bt held high throughout BG -> req_pending stays 0 in BG and BY. bt still high in R2 sets req_pending, so after 4 AG cycles the cycle repeats.
- night=1 in AG:
  - FL next edge, with A=B=010 for 2 cycles, 000 for 2, 010 for 2, and so on. bt is ignored.
  - night=0 -> R2 for 1 cycle -> AG.
  - night raised during BG -> full B sequence completes, then FL one edge after AG is entered.
- rst asserted while in BG -> next edge A=100, B=001, phase=0, req_pending=0, timer=0.
